control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 89 ++++++++
 rtl/control_unit_opcode_decode.sv | 57 +++++
 rtl/control_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_unit_pkg
// Description : Shared definitions for the multi-cycle control unit:
//               opcode constants, ALU function codes, branch condition
//               codes, FSM state encoding, instruction classes and the
//               bundled control-strobe word.
// Revision    : 1.0 - initial release
// ============================================================================
package control_unit_pkg;

    // Opcodes, irout[31:26]
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b000001;
    localparam logic [5:0] c_op_lw    = 6'b000010;
    localparam logic [5:0] c_op_sw    = 6'b000011;
    localparam logic [5:0] c_op_beqz  = 6'b000100;
    localparam logic [5:0] c_op_bnez  = 6'b000101;
    localparam logic [5:0] c_op_bltz  = 6'b000110;
    localparam logic [5:0] c_op_j     = 6'b000111;
    localparam logic [5:0] c_op_halt  = 6'b111111;

    // ALU function codes
    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0001;
    localparam logic [3:0] c_alu_and = 4'b0010;
    localparam logic [3:0] c_alu_or  = 4'b0011;
    localparam logic [3:0] c_alu_xor = 4'b0100;

    // PC source condition codes
    localparam logic [1:0] c_cond_eqz   = 2'b00;
    localparam logic [1:0] c_cond_nez   = 2'b01;
    localparam logic [1:0] c_cond_ltz   = 2'b10;
    localparam logic [1:0] c_cond_never = 2'b11;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EX_R   = 4'd2,
        ST_EX_I   = 4'd3,
        ST_EX_MA  = 4'd4,
        ST_EX_BR  = 4'd5,
        ST_BR_PC  = 4'd6,
        ST_J_PC   = 4'd7,
        ST_MEM_RD = 4'd8,
        ST_MEM_WR = 4'd9,
        ST_WB_ALU = 4'd10,
        ST_WB_LD  = 4'd11,
        ST_HALT   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ADDI   = 3'd2,
        CLS_LW     = 3'd3,
        CLS_SW     = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_JUMP   = 3'd6,
        CLS_HALT   = 3'd7
    } iclass_t;

    // Every control output in one word so the reset gating is applied once.
    typedef struct packed {
        logic       readim;
        logic       ldir;
        logic       ldnpc;
        logic       ldimm;
        logic       lda;
        logic       ldb;
        logic       alusel1;
        logic       alusel2;
        logic       aluen;
        logic       ldaluout;
        logic [3:0] alufunc;
        logic [1:0] opcond;
        logic       seldest;
        logic       regwrite;
        logic       writedmem;
        logic       readdmem;
        logic       ldlmd;
        logic       selwb;
        logic       branch;
        logic       ldpc;
        logic       halted;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_unit_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : opcode_decode
// Description : Classifies the instruction held in the IR.
// Ports       : irout   - IR contents (only the opcode field is examined)
//               iclass  - instruction class
//               opcond  - PC source condition for conditional branches,
//                         "never" for everything else
//               seldest - 1 selects rt (I-type writers), 0 selects rd
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_decode
    import control_unit_pkg::*;
(
    input  logic [31:0] irout,
    output iclass_t     iclass,
    output logic [1:0]  opcond,
    output logic        seldest
);

    logic [5:0] w_opcode;
    logic       w_unused_fields;

    assign w_opcode        = irout[31:26];
    assign w_unused_fields = ^irout[25:0];

    always_comb begin
        iclass = CLS_NOP;
        opcond = c_cond_never;
        case (w_opcode)
            c_op_rtype: iclass = CLS_RTYPE;
            c_op_addi:  iclass = CLS_ADDI;
            c_op_lw:    iclass = CLS_LW;
            c_op_sw:    iclass = CLS_SW;
            c_op_beqz: begin
                iclass = CLS_BRANCH;
                opcond = c_cond_eqz;
            end
            c_op_bnez: begin
                iclass = CLS_BRANCH;
                opcond = c_cond_nez;
            end
            c_op_bltz: begin
                iclass = CLS_BRANCH;
                opcond = c_cond_ltz;
            end
            c_op_j:     iclass = CLS_JUMP;
            c_op_halt:  iclass = CLS_HALT;
            default:    iclass = CLS_NOP;
        endcase
    end

    // I-type instructions that write the register file name rt as destination.
    assign seldest = (iclass == CLS_ADDI) || (iclass == CLS_LW);

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Moore-style multi-cycle control FSM for a small load/store
//               processor, with a retired-instruction counter.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous active-low reset
//               irout        - instruction register contents
//               readim..ldimm- instruction fetch strobes
//               ldA, ldB     - operand register loads
//               alusel1/2, aluen, ldaluout, alufunc - ALU control
//               opcond, branch, ldpc - PC update control
//               seldest, regwrite, selwb - register write-back control
//               writedmem, readdmem, ldlmd - data memory control
//               halted       - FSM parked in HALT
//               instr_count  - count of cycles with ldpc asserted
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import control_unit_pkg::*;
#(
    // Value instr_count takes while reset is asserted; 0 in normal use,
    // other values allow the counter to be preloaded.
    parameter logic [31:0] INSTR_COUNT_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] irout,
    output logic        readim,
    output logic        ldir,
    output logic        ldnpc,
    output logic        ldimm,
    output logic        ldA,
    output logic        ldB,
    output logic        alusel1,
    output logic        alusel2,
    output logic        aluen,
    output logic        ldaluout,
    output logic [3:0]  alufunc,
    output logic [1:0]  opcond,
    output logic        seldest,
    output logic        regwrite,
    output logic        writedmem,
    output logic        readdmem,
    output logic        ldlmd,
    output logic        selwb,
    output logic        branch,
    output logic        ldpc,
    output logic        halted,
    output logic [31:0] instr_count
);

    state_t      r_state;
    state_t      w_next_state;
    ctrl_t       w_ctrl;
    ctrl_t       w_ctrl_out;
    iclass_t     w_iclass;
    logic [1:0]  w_dec_opcond;
    logic        w_dec_seldest;
    logic [31:0] r_instr_count;

    opcode_decode u_opcode_decode (
        .irout   (irout),
        .iclass  (w_iclass),
        .opcond  (w_dec_opcond),
        .seldest (w_dec_seldest)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_ctrl       = '0;
        w_next_state = r_state;
        case (r_state)
            ST_IF: begin
                // The immediate register is loaded from the instruction
                // memory output, so it is captured alongside the IR.
                w_ctrl.readim = 1'b1;
                w_ctrl.ldir   = 1'b1;
                w_ctrl.ldnpc  = 1'b1;
                w_ctrl.ldimm  = 1'b1;
                w_next_state  = ST_ID;
            end
            ST_ID: begin
                w_ctrl.lda = 1'b1;
                w_ctrl.ldb = 1'b1;
                case (w_iclass)
                    CLS_RTYPE:  w_next_state = ST_EX_R;
                    CLS_ADDI:   w_next_state = ST_EX_I;
                    CLS_LW,
                    CLS_SW:     w_next_state = ST_EX_MA;
                    CLS_BRANCH: w_next_state = ST_EX_BR;
                    CLS_JUMP:   w_next_state = ST_J_PC;
                    CLS_HALT:   w_next_state = ST_HALT;
                    default: begin
                        // Unrecognised opcode retires here as a NOP.
                        w_ctrl.ldpc   = 1'b1;
                        w_ctrl.opcond = c_cond_never;
                        w_next_state  = ST_IF;
                    end
                endcase
            end
            ST_EX_R: begin
                w_ctrl.alusel1  = 1'b1;
                w_ctrl.alufunc  = irout[3:0];
                w_ctrl.aluen    = 1'b1;
                w_ctrl.ldaluout = 1'b1;
                w_next_state    = ST_WB_ALU;
            end
            ST_EX_I, ST_EX_MA: begin
                w_ctrl.alusel1  = 1'b1;
                w_ctrl.alusel2  = 1'b1;
                w_ctrl.alufunc  = c_alu_add;
                w_ctrl.aluen    = 1'b1;
                w_ctrl.ldaluout = 1'b1;
                if (r_state == ST_EX_I) begin
                    w_next_state = ST_WB_ALU;
                end else if (w_iclass == CLS_SW) begin
                    w_next_state = ST_MEM_WR;
                end else begin
                    w_next_state = ST_MEM_RD;
                end
            end
            ST_EX_BR: begin
                // Target = NPC + immediate.
                w_ctrl.alusel2  = 1'b1;
                w_ctrl.alufunc  = c_alu_add;
                w_ctrl.aluen    = 1'b1;
                w_ctrl.ldaluout = 1'b1;
                w_next_state    = ST_BR_PC;
            end
            ST_BR_PC: begin
                w_ctrl.ldpc   = 1'b1;
                w_ctrl.opcond = w_dec_opcond;
                w_next_state  = ST_IF;
            end
            ST_J_PC: begin
                w_ctrl.ldpc   = 1'b1;
                w_ctrl.branch = 1'b1;
                w_next_state  = ST_IF;
            end
            ST_MEM_RD: begin
                w_ctrl.readdmem = 1'b1;
                w_ctrl.ldlmd    = 1'b1;
                w_next_state    = ST_WB_LD;
            end
            ST_MEM_WR: begin
                w_ctrl.writedmem = 1'b1;
                w_ctrl.ldpc      = 1'b1;
                w_ctrl.opcond    = c_cond_never;
                w_next_state     = ST_IF;
            end
            ST_WB_ALU: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.selwb    = 1'b1;
                w_ctrl.seldest  = w_dec_seldest;
                w_ctrl.ldpc     = 1'b1;
                w_ctrl.opcond   = c_cond_never;
                w_next_state    = ST_IF;
            end
            ST_WB_LD: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.seldest  = 1'b1;
                w_ctrl.ldpc     = 1'b1;
                w_ctrl.opcond   = c_cond_never;
                w_next_state    = ST_IF;
            end
            ST_HALT: begin
                w_ctrl.halted = 1'b1;
                w_next_state  = ST_HALT;
            end
            default: begin
                w_next_state = ST_IF;
            end
        endcase
    end

    // The state register returns to IF under reset, but IF drives fetch
    // strobes; masking with reset keeps every output quiet until release.
    assign w_ctrl_out = reset ? w_ctrl : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_count <= INSTR_COUNT_RESET;
        end else if (w_ctrl.ldpc) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign readim      = w_ctrl_out.readim;
    assign ldir        = w_ctrl_out.ldir;
    assign ldnpc       = w_ctrl_out.ldnpc;
    assign ldimm       = w_ctrl_out.ldimm;
    assign ldA         = w_ctrl_out.lda;
    assign ldB         = w_ctrl_out.ldb;
    assign alusel1     = w_ctrl_out.alusel1;
    assign alusel2     = w_ctrl_out.alusel2;
    assign aluen       = w_ctrl_out.aluen;
    assign ldaluout    = w_ctrl_out.ldaluout;
    assign alufunc     = w_ctrl_out.alufunc;
    assign opcond      = w_ctrl_out.opcond;
    assign seldest     = w_ctrl_out.seldest;
    assign regwrite    = w_ctrl_out.regwrite;
    assign writedmem   = w_ctrl_out.writedmem;
    assign readdmem    = w_ctrl_out.readdmem;
    assign ldlmd       = w_ctrl_out.ldlmd;
    assign selwb       = w_ctrl_out.selwb;
    assign branch      = w_ctrl_out.branch;
    assign ldpc        = w_ctrl_out.ldpc;
    assign halted      = w_ctrl_out.halted;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire
